// File: rtl/alu_pkg.sv
// Shared encodings, FSM state type and width helpers for the ALU / multiply-divide block.
package alu_pkg;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_OR   = 4'd2,
        ALU_PACK = 4'd3,
        ALU_SLL  = 4'd4,
        ALU_AND  = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_SLT  = 4'd10,
        ALU_SLTU = 4'd11,
        ALU_LUI  = 4'd12,
        ALU_MFHI = 4'd13,
        ALU_MFLO = 4'd14,
        ALU_NOP  = 4'd15
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_NOP6  = 3'd6,
        MD_NOP7  = 3'd7
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    function automatic int shamt_w(input int width);
        return $clog2(width);
    endfunction

    // Counter must hold values up to max(cycles)-1.
    function automatic int cnt_w(input int mult_cycles, input int div_cycles);
        return $clog2(((mult_cycles > div_cycles) ? mult_cycles : div_cycles) + 1);
    endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response bus between the ALU top and the multi-cycle multiply/divide unit.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       op;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output op, start, a, b, input busy, hi, lo);
    modport slave  (input op, start, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide engine: IDLE/RUN FSM, latched operands, HI/LO registers.
module md_unit
    import alu_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic      clk,
    input  logic      rst,
    alu_mdu_if.slave  bus
);
    localparam int CW = cnt_w(MULT_CYCLES, DIV_CYCLES);

    md_state_e        state, state_nx;
    logic [CW-1:0]    cnt;
    md_op_e           op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             accept, long_op, is_div, is_signed, done;
    logic [CW-1:0]    last;

    assign accept    = (state == IDLE) && bus.start;
    assign long_op   = accept && (bus.op[2] == 1'b0);
    assign is_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);
    assign is_signed = (op_q == MD_MULT) || (op_q == MD_DIV);
    assign last      = is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
    assign done      = (state == RUN) && (cnt == last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (long_op) state_nx = RUN;
            RUN:     if (done)    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.hi   = hi_q;
        bus.lo   = lo_q;
    end

    // Result datapath works only from latched operands.
    logic [2*WIDTH-1:0] a_x, b_x, prod;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b, uq, ur, quo, rem;

    always_comb begin
        a_x   = {{WIDTH{is_signed & a_q[WIDTH-1]}}, a_q};
        b_x   = {{WIDTH{is_signed & b_q[WIDTH-1]}}, b_q};
        prod  = a_x * b_x;
        neg_a = is_signed & a_q[WIDTH-1];
        neg_b = is_signed & b_q[WIDTH-1];
        mag_a = neg_a ? -a_q : a_q;
        mag_b = neg_b ? -b_q : b_q;
        uq    = '0;
        ur    = '0;
        if (mag_b != '0) begin
            uq = mag_a / mag_b;
            ur = mag_a % mag_b;
        end
        // Sign-magnitude division: truncates toward zero and MIN/-1 wraps back to MIN.
        quo   = (neg_a ^ neg_b) ? -uq : uq;
        rem   = neg_a ? -ur : ur;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            op_q <= MD_MULT;
            a_q  <= '0;
            b_q  <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (long_op) begin
                cnt  <= '0;
                op_q <= md_op_e'(bus.op);
                a_q  <= bus.a;
                b_q  <= bus.b;
            end else if (state == RUN) begin
                cnt <= done ? '0 : cnt + 1'b1;
            end

            if (accept && (bus.op == MD_MTHI)) hi_q <= bus.a;
            if (accept && (bus.op == MD_MTLO)) lo_q <= bus.a;

            if (done) begin
                if (!is_div) begin
                    hi_q <= prod[2*WIDTH-1:WIDTH];
                    lo_q <= prod[WIDTH-1:0];
                end else if (b_q != '0) begin
                    hi_q <= rem;
                    lo_q <= quo;
                end
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Combinational ALU with MFHI/MFLO mux, wrapped around the multi-cycle md_unit.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ALUop,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic [WIDTH-1:0] ALUout,
    output logic             Zero,
    output logic             Overflow,
    input  logic [2:0]       MDop,
    input  logic             MDstart,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int SW = shamt_w(WIDTH);
    localparam int H  = WIDTH / 2;

    alu_mdu_if #(.WIDTH(WIDTH)) md_bus ();

    assign md_bus.op    = MDop;
    assign md_bus.start = MDstart;
    assign md_bus.a     = in_1;
    assign md_bus.b     = in_2;
    assign busy         = md_bus.busy;
    assign HI           = md_bus.hi;
    assign LO           = md_bus.lo;

    md_unit #(
        .WIDTH      (WIDTH),
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md (
        .clk(clk),
        .rst(reset),
        .bus(md_bus.slave)
    );

    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] sum, diff;
    logic             add_ovf, sub_ovf;

    assign shamt   = in_2[SW-1:0];
    assign sum     = in_1 + in_2;
    assign diff    = in_1 - in_2;
    // Signed overflow: result sign differs from A where operand signs make it impossible.
    assign add_ovf = (in_1[WIDTH-1] == in_2[WIDTH-1]) && (sum[WIDTH-1]  != in_1[WIDTH-1]);
    assign sub_ovf = (in_1[WIDTH-1] != in_2[WIDTH-1]) && (diff[WIDTH-1] != in_1[WIDTH-1]);

    always_comb begin
        ALUout   = '0;
        Overflow = 1'b0;
        case (alu_op_e'(ALUop))
            ALU_ADD:  begin ALUout = sum;  Overflow = add_ovf; end
            ALU_SUB:  begin ALUout = diff; Overflow = sub_ovf; end
            ALU_OR:   ALUout = in_1 | in_2;
            ALU_PACK: ALUout = {in_2[H-1:0], in_1[H-1:0]};
            ALU_SLL:  ALUout = in_1 << shamt;
            ALU_AND:  ALUout = in_1 & in_2;
            ALU_XOR:  ALUout = in_1 ^ in_2;
            ALU_NOR:  ALUout = ~(in_1 | in_2);
            ALU_SRL:  ALUout = in_1 >> shamt;
            ALU_SRA:  ALUout = $signed(in_1) >>> shamt;
            ALU_SLT:  ALUout = {{(WIDTH-1){1'b0}}, ($signed(in_1) < $signed(in_2))};
            ALU_SLTU: ALUout = {{(WIDTH-1){1'b0}}, (in_1 < in_2)};
            ALU_LUI:  ALUout = {in_2[H-1:0], {H{1'b0}}};
            ALU_MFHI: ALUout = HI;
            ALU_MFLO: ALUout = LO;
            default:  ALUout = '0;
        endcase
    end

    assign Zero = (ALUout == '0);

endmodule
